// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared types and defaults for the PDM playback transmitter
package pdm_pkg;

    localparam int DBITS_DEF    = 16;
    localparam int CLK_DIV_DEF  = 50;
    localparam int OSR_DEF      = 64;
    localparam int MIDSCALE_OFS = 2 ** (DBITS_DEF - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        RUN
    } state_t;

endpackage

// File: rtl/pdm_playback_tx_if.sv
// rtl/pdm_playback_tx_if.sv - audio FIFO read port between FIFO and playback reader
interface pdm_playback_tx_if #(
    parameter int DBITS = 16
);
    logic             fifo_empty;
    logic             fifo_rd;
    logic [DBITS-1:0] fifo_dout;

    // master is the reader issuing pops; slave is the FIFO supplying data
    modport master (output fifo_rd, input fifo_empty, input fifo_dout);
    modport slave  (input fifo_rd, output fifo_empty, output fifo_dout);
endinterface

// File: rtl/sdm1_mod.sv
// rtl/sdm1_mod.sv - first-order sigma-delta modulator, one output bit per bit_tick
module sdm1_mod #(
    parameter int DBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_tick,
    input  logic             clr,
    input  logic [DBITS-1:0] sample,
    output logic             pdm
);
    logic [DBITS-1:0] acc;
    logic [DBITS-1:0] u;
    logic [DBITS:0]   sum;

    // two's complement to offset binary so midscale gives 50% ones density
    assign u   = {~sample[DBITS-1], sample[DBITS-2:0]};
    assign sum = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            pdm <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            pdm <= 1'b0;
        end else if (bit_tick) begin
            acc <= sum[DBITS-1:0];
            pdm <= sum[DBITS];
        end
    end
endmodule

// File: rtl/pdm_playback_tx.sv
// rtl/pdm_playback_tx.sv - FIFO-fed PCM to PDM playback with bit clock and amplifier control
module pdm_playback_tx
    import pdm_pkg::*;
#(
    parameter int DBITS   = DBITS_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int OSR     = OSR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    pdm_playback_tx_if.master fifo,
    output logic              mclk,
    output logic              amp_pwm,
    output logic              amp_sd,
    output logic              sample_tick,
    output logic              underrun,
    input  logic              underrun_clr
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int OSR_W = $clog2(OSR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [OSR_W-1:0] osr_cnt;
    logic [DBITS-1:0] cur_smp;
    logic [DBITS-1:0] nxt_smp;
    logic             bit_tick;
    logic             boundary;
    logic             empty_fetch;
    logic             sdm_clr;

    assign bit_tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign boundary    = bit_tick && (osr_cnt == OSR_LAST);
    assign div_nxt     = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    assign empty_fetch = en && (state == FETCH) && fifo.fifo_empty;
    assign sdm_clr     = ~en;

    // pop is combinational so the word lands in time for the WAIT capture
    assign fifo.fifo_rd = en && (state == FETCH) && !fifo.fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            osr_cnt     <= '0;
            cur_smp     <= '0;
            nxt_smp     <= '0;
            mclk        <= 1'b0;
            amp_sd      <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= en && boundary;

            if (empty_fetch) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            if (!en) begin
                state   <= IDLE;
                div_cnt <= '0;
                osr_cnt <= '0;
                mclk    <= 1'b0;
                amp_sd  <= 1'b0;
            end else if (state == IDLE) begin
                state  <= FETCH;
                amp_sd <= 1'b1;
                mclk   <= 1'b1;
            end else begin
                div_cnt <= div_nxt;
                mclk    <= (div_nxt < DIV_HALF);
                if (bit_tick) begin
                    osr_cnt <= osr_cnt + 1'b1;
                end
                case (state)
                    FETCH: begin
                        if (!fifo.fifo_empty) begin
                            state <= WAIT;
                        end else begin
                            nxt_smp <= cur_smp;
                            state   <= RUN;
                        end
                    end
                    WAIT: begin
                        nxt_smp <= fifo.fifo_dout;
                        state   <= RUN;
                    end
                    RUN: begin
                        if (boundary) begin
                            cur_smp <= nxt_smp;
                            state   <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sdm1_mod #(.DBITS(DBITS)) u_sdm1 (
        .clk      (clk),
        .reset    (reset),
        .bit_tick (bit_tick),
        .clr      (sdm_clr),
        .sample   (cur_smp),
        .pdm      (amp_pwm)
    );
endmodule

// File: tb/tb_pdm_playback_tx.sv
// tb/tb_pdm_playback_tx.sv - bench for pdm_playback_tx against an arithmetic density model
module tb_pdm_playback_tx;
    import pdm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic underrun_clr;
    logic mclk, amp_pwm, amp_sd, sample_tick, underrun;

    pdm_playback_tx_if #(.DBITS(16)) fifo_if ();

    always #5 clk = ~clk;

    pdm_playback_tx dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .fifo         (fifo_if.master),
        .mclk         (mclk),
        .amp_pwm      (amp_pwm),
        .amp_sd       (amp_sd),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    logic [15:0] mem [0:63];
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int rd_count = 0;
    int bad_rd   = 0;

    assign fifo_if.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_if.fifo_rd) begin
            fifo_if.fifo_dout <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 1;
            rd_count          <= rd_count + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_if.fifo_rd && (!en || reset)) bad_rd++;
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] mq [$];
    logic [15:0] model_cur, model_nxt;
    longint      model_acc;
    int          model_pops;
    bit          model_ur;
    bit          skip_first;
    time         last_rise_t;
    time         rise_gap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
        mq.push_back(w);
    endtask

    function automatic int u_of(input logic [15:0] s);
        return int'($signed(s)) + MIDSCALE_OFS;
    endfunction

    // what the next-sample fetch would stage: a fresh word, or a repeat on empty
    function automatic void stage();
        if (mq.size() > 0) begin
            model_nxt = mq.pop_front();
            model_pops++;
        end else begin
            model_nxt = model_cur;
            model_ur  = 1'b1;
        end
    endfunction

    // counts PDM bits at each mclk rise until the sample_tick closing the sample
    task automatic run_sample(input int clr_at, output int ones, output int nbits, output bit timed_out);
        logic prev;
        prev      = mclk;
        ones      = 0;
        nbits     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            underrun_clr = (i == clr_at);
            if (mclk && !prev) begin
                if (skip_first) begin
                    skip_first = 1'b0;
                end else begin
                    ones  += int'(amp_pwm);
                    nbits += 1;
                end
                rise_gap    = $time - last_rise_t;
                last_rise_t = $time;
            end
            prev = mclk;
            if (sample_tick) begin
                timed_out = 1'b0;
                break;
            end
        end
        underrun_clr = 1'b0;
    endtask

    task automatic do_sample(input string tag, input int clr_at);
        int     ones, nbits, exp_ones;
        bit     to;
        longint tot;
        run_sample(clr_at, ones, nbits, to);
        tot       = model_acc + 64 * longint'(u_of(model_cur));
        exp_ones  = int'(tot / 65536);
        model_acc = tot % 65536;
        if (clr_at >= 0) model_ur = 1'b0;
        check($sformatf("%s timeout", tag), 32'(to), 32'd0);
        check($sformatf("%s nbits", tag), nbits, 64);
        check($sformatf("%s ones", tag), ones, exp_ones);
        check($sformatf("%s pops", tag), rd_count, model_pops);
        check($sformatf("%s underrun", tag), 32'(underrun), 32'(model_ur));
        model_cur = model_nxt;
        stage();
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        underrun_clr = 1'b0;
        skip_first   = 1'b0;
        last_rise_t  = 0;
        rise_gap     = 0;
        repeat (3) @(negedge clk);
        check("rst fifo_rd", 32'(fifo_if.fifo_rd), 0);
        check("rst mclk", 32'(mclk), 0);
        check("rst amp_pwm", 32'(amp_pwm), 0);
        check("rst amp_sd", 32'(amp_sd), 0);
        check("rst sample_tick", 32'(sample_tick), 0);
        check("rst underrun", 32'(underrun), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle amp_sd", 32'(amp_sd), 0);

        push(16'h0000);
        push(16'h0000);
        push(16'h8000);
        push(16'h7FFF);
        for (int i = 0; i < 4; i++) push(16'($urandom_range(0, 65535)));
        push(16'h4000);

        model_cur  = '0;
        model_acc  = 0;
        model_pops = 0;
        model_ur   = 1'b0;
        skip_first = 1'b1;
        en         = 1'b1;
        stage();
        do_sample("smp1", -1);
        check("mclk period", 32'(rise_gap), 32'd500);
        check("amp_sd on", 32'(amp_sd), 1);
        for (int k = 2; k <= 10; k++) do_sample($sformatf("smp%0d", k), -1);

        do_sample("clr_mid", 1000);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("clr vs set", 32'(underrun), 32'(model_ur));

        for (int i = 0; i < 3; i++) push(16'($urandom_range(0, 65535)));
        do_sample("pre_drop", -1);
        @(negedge clk);
        en        = 1'b0;
        model_nxt = model_cur;
        @(negedge clk);
        check("drop amp_sd", 32'(amp_sd), 0);
        check("drop amp_pwm", 32'(amp_pwm), 0);
        check("drop mclk", 32'(mclk), 0);
        check("drop fifo_rd", 32'(fifo_if.fifo_rd), 0);
        repeat (30) @(negedge clk);
        check("drop pops", rd_count, model_pops);
        check("drop underrun kept", 32'(underrun), 32'(model_ur));

        model_acc  = 0;
        skip_first = 1'b1;
        en         = 1'b1;
        stage();
        do_sample("resume1", -1);
        do_sample("resume2", -1);

        repeat (700) @(negedge clk);
        check("pre_rst underrun", 32'(underrun), 32'(model_ur));
        reset = 1'b1;
        en    = 1'b0;
        #1;
        check("arst fifo_rd", 32'(fifo_if.fifo_rd), 0);
        check("arst mclk", 32'(mclk), 0);
        check("arst amp_pwm", 32'(amp_pwm), 0);
        check("arst amp_sd", 32'(amp_sd), 0);
        check("arst sample_tick", 32'(sample_tick), 0);
        check("arst underrun", 32'(underrun), 0);
        @(negedge clk);
        reset = 1'b0;
        push(16'($urandom_range(0, 65535)));
        repeat (100) @(negedge clk);
        check("post_rst mclk", 32'(mclk), 0);
        check("post_rst amp_sd", 32'(amp_sd), 0);
        check("post_rst pops", rd_count, model_pops);

        model_cur  = '0;
        model_nxt  = '0;
        model_acc  = 0;
        model_ur   = 1'b0;
        skip_first = 1'b1;
        en         = 1'b1;
        stage();
        do_sample("post_rst", -1);
        check("no rd while disabled", bad_rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
